// File: rtl/dds_waveform_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dds_waveform_gen
//   Direct digital synthesis waveform generator. A 32-bit phase accumulator
//   advances by phase_inc on every enabled clock; its top 12 bits (p) select
//   sine, cosine, square and sawtooth samples, all 12-bit two's complement.
//   Outputs are registered from the current accumulator value, so they lag
//   the accumulator by one clock and a phase_inc change by two clocks.
//
//   The quarter-wave sine table (1025 entries, 11-bit magnitudes,
//   Q[i] = round(2047*sin(2*pi*i/4096))) is built at elaboration time by a
//   constant function, so no memory image has to be shipped with the netlist.
//   SIN_LUT_FILE names the equivalent ROM image for flows that expect one.
//
// Ports
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high: clears accumulator and outputs
//   en         in   1   1 = accumulate phase_inc this cycle, 0 = hold phase
//   phase_inc  in   32  unsigned tuning word
//   sin_out    out  12  signed sine
//   cos_out    out  12  signed cosine
//   squ_out    out  12  signed square (+2047 / -2048)
//   saw_out    out  12  signed sawtooth (p - 2048)
//   tri_out    out  12  signed triangle (only with DDS_TRI_OUT_EN defined)
//
// Configuration macro
//   DDS_TRI_OUT_EN : adds the registered triangle output tri_out.
// -----------------------------------------------------------------------------
module dds_waveform_gen #(
   parameter string SIN_LUT_FILE = "sin_quarter.hex"
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [31:0]        phase_inc,
   output logic signed [11:0] sin_out,
   output logic signed [11:0] cos_out,
   output logic signed [11:0] squ_out,
   output logic signed [11:0] saw_out
`ifdef DDS_TRI_OUT_EN
   ,
   output logic signed [11:0] tri_out
`endif
);

   localparam int DATA_W = 12;
   localparam int MAG_W  = 11;
   localparam int QTR    = 1024;

   // pi in unsigned Q60 fixed point (truncated)
   localparam logic signed [127:0] PI_Q60 = 128'sh3243_F6A8_885A_308D;

   // The ROM image name has no effect on the generated table.
   logic lut_file_named_unused;
   assign lut_file_named_unused = (SIN_LUT_FILE != "");

   // Q[idx] = round(2047*sin(pi*idx/2048)) via a Q60 Taylor series; the
   // residual error is far below one LSB, so the rounding is exact.
   function automatic logic [MAG_W-1:0] quarter_sine(input int idx);
      logic signed [127:0] x;
      logic signed [127:0] term;
      logic signed [127:0] sum;
      logic signed [127:0] scaled;
      x    = (PI_Q60 * 128'(idx)) >>> 11;
      term = x;
      sum  = x;
      for (int k = 1; k <= 12; k++) begin
         term = (term * x) >>> 60;
         term = (term * x) >>> 60;
         term = -term / 128'(2 * k * (2 * k + 1));
         sum  = sum + term;
      end
      scaled = (sum * 128'sd2047 + (128'sd1 <<< 59)) >>> 60;
      return scaled[MAG_W-1:0];
   endfunction

   // Mirror the quarter index for quadrants 01 and 11.
   function automatic logic [MAG_W-1:0] fold_index(input logic [11:0] ph);
      return ph[10] ? (MAG_W'(QTR) - {1'b0, ph[9:0]}) : {1'b0, ph[9:0]};
   endfunction

   function automatic logic signed [DATA_W-1:0] apply_sign(
      input logic [MAG_W-1:0] mag,
      input logic             neg
   );
      logic signed [DATA_W-1:0] m;
      m = $signed({1'b0, mag});
      return neg ? -m : m;
   endfunction

   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [14:0] v);
      if (v > 15'sd2047) begin
         return 12'sh7FF;
      end else if (v < -15'sd2048) begin
         return 12'sh800;
      end else begin
         return $signed(v[DATA_W-1:0]);
      end
   endfunction

   logic [MAG_W-1:0] q_rom [0:QTR];

   for (genvar gi = 0; gi <= QTR; gi++) begin : g_rom
      localparam logic [MAG_W-1:0] QV = quarter_sine(gi);
      assign q_rom[gi] = QV;
   end

   logic [31:0]              acc_q, acc_d;
   logic signed [DATA_W-1:0] sin_q, sin_d;
   logic signed [DATA_W-1:0] cos_q, cos_d;
   logic signed [DATA_W-1:0] squ_q, squ_d;
   logic signed [DATA_W-1:0] saw_q, saw_d;
   logic [11:0]              p;
   logic [11:0]              pc;

   assign p  = acc_q[31:20];
   assign pc = p + 12'd1024;

   // Stage 0: phase accumulator; stage 1: waveform samples from acc_q.
   always_comb begin
      acc_d = en ? (acc_q + phase_inc) : acc_q;
      sin_d = apply_sign(q_rom[fold_index(p)], p[11]);
      cos_d = apply_sign(q_rom[fold_index(pc)], pc[11]);
      squ_d = p[11] ? 12'sh800 : 12'sh7FF;
      saw_d = $signed({~p[11], p[10:0]});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         sin_q <= '0;
         cos_q <= '0;
         squ_q <= '0;
         saw_q <= '0;
      end else begin
         acc_q <= acc_d;
         sin_q <= sin_d;
         cos_q <= cos_d;
         squ_q <= squ_d;
         saw_q <= saw_d;
      end
   end

   assign sin_out = sin_q;
   assign cos_out = cos_q;
   assign squ_out = squ_q;
   assign saw_out = saw_q;

`ifdef DDS_TRI_OUT_EN
   logic signed [DATA_W-1:0] tri_q, tri_d;
   logic signed [14:0]       p_dbl;
   logic signed [14:0]       tri_lin;

   assign p_dbl = $signed({2'b00, p, 1'b0});

   // Stage 1 (triangle): rising half 2p-2048, falling half 6143-2p.
   always_comb begin
      tri_lin = p[11] ? (15'sd6143 - p_dbl) : (p_dbl - 15'sd2048);
      tri_d   = sat_data(tri_lin);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tri_q <= '0;
      end else begin
         tri_q <= tri_d;
      end
   end

   assign tri_out = tri_q;
`else
   // Triangle path absent; the saturation helper stays unreferenced.
`endif

endmodule

// File: tb/tb_dds_waveform_gen.sv
`timescale 1ns/1ps
module tb_dds_waveform_gen;

   logic               clk = 1'b0;
   logic               reset;
   logic               en;
   logic [31:0]        phase_inc;
   logic signed [11:0] sin_out;
   logic signed [11:0] cos_out;
   logic signed [11:0] squ_out;
   logic signed [11:0] saw_out;
`ifdef DDS_TRI_OUT_EN
   logic signed [11:0] tri_out;
   int                 tri_by_p [0:4095];
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_acc    = 32'd0;
   int          last_p   = 0;
   int          sin_by_p [0:4095];
   int          cos_by_p [0:4095];

   localparam real TWO_PI = 6.283185307179586;

   dds_waveform_gen dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .phase_inc (phase_inc),
      .sin_out   (sin_out),
      .cos_out   (cos_out),
      .squ_out   (squ_out),
`ifdef DDS_TRI_OUT_EN
      .tri_out   (tri_out),
`endif
      .saw_out   (saw_out)
   );

   always #10 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference waveforms straight from the formulas.
   function automatic int round_half_away(input real r);
      if (r >= 0.0) return $rtoi(r + 0.5);
      else          return -$rtoi(-r + 0.5);
   endfunction

   function automatic int ref_sin(input int p);
      return round_half_away(2047.0 * $sin(TWO_PI * p / 4096.0));
   endfunction

   function automatic int ref_cos(input int p);
      return round_half_away(2047.0 * $cos(TWO_PI * p / 4096.0));
   endfunction

   function automatic int ref_squ(input int p);
      return (p < 2048) ? 2047 : -2048;
   endfunction

   function automatic int ref_saw(input int p);
      return p - 2048;
   endfunction

   function automatic int ref_tri(input int p);
      int t;
      t = (p >= 2048) ? (6143 - 2 * p) : (2 * p - 2048);
      if (t > 2047)  t = 2047;
      if (t < -2048) t = -2048;
      return t;
   endfunction

   // One clock: drive inputs, advance the model across the edge, compare.
   task automatic step(input bit r, input bit e, input logic [31:0] inc);
      int p;
      reset     = r;
      en        = e;
      phase_inc = inc;
      @(posedge clk);
      p      = int'(m_acc[31:20]);
      last_p = p;
      m_acc  = r ? 32'd0 : (e ? (m_acc + inc) : m_acc);
      #1;
      check_val("sin", sin_out, r ? 0 : ref_sin(p));
      check_val("cos", cos_out, r ? 0 : ref_cos(p));
      check_val("squ", squ_out, r ? 0 : ref_squ(p));
      check_val("saw", saw_out, r ? 0 : ref_saw(p));
`ifdef DDS_TRI_OUT_EN
      check_val("tri", tri_out, r ? 0 : ref_tri(p));
`endif
   endtask

   initial begin
      int t2_saw [5];
      int t2_sin [5];
      int prev_s, prev_c, prev_q, prev_w;
      logic [31:0] inc;
      t2_saw = '{-2048, -1025, -1, 1023, 2047};
      t2_sin = '{0, 2047, 3, -2047, -3};

      reset = 1'b1; en = 1'b0; phase_inc = 32'd0;

      // Reset for two cycles, then idle with en low.
      step(1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'd0);
      check_val("rst_sin", sin_out, 0);
      check_val("rst_cos", cos_out, 0);
      check_val("rst_squ", squ_out, 0);
      check_val("rst_saw", saw_out, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'd0);
         check_val("idle_sin", sin_out, 0);
         check_val("idle_cos", cos_out, 2047);
         check_val("idle_squ", squ_out, 2047);
         check_val("idle_saw", saw_out, -2048);
      end

      // Quarter-rate tuning word.
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 32'd1073741820);
         check_val("qrate_saw", saw_out, t2_saw[i]);
         check_val("qrate_sin", sin_out, t2_sin[i]);
      end

      // Full sweep, one phase index per clock.
      for (int i = 0; i < 4096; i++) begin
         step(1'b0, 1'b1, 32'h0010_0000);
         sin_by_p[last_p] = sin_out;
         cos_by_p[last_p] = cos_out;
`ifdef DDS_TRI_OUT_EN
         tri_by_p[last_p] = tri_out;
`endif
      end
      for (int i = 0; i < 16; i++) begin
         int pp;
         pp = $urandom_range(0, 4095);
         check_val("cos_vs_sin_shift", cos_by_p[pp], sin_by_p[(pp + 1024) % 4096]);
      end
`ifdef DDS_TRI_OUT_EN
      begin
         int bad;
         bad = 0;
         check_val("tri_p0", tri_by_p[0], -2048);
         check_val("tri_p2048", tri_by_p[2048], 2047);
         for (int i = 1; i <= 2048; i++)
            if (tri_by_p[i] <= tri_by_p[i-1]) bad++;
         for (int i = 2049; i < 4096; i++)
            if (tri_by_p[i] >= tri_by_p[i-1]) bad++;
         check_val("tri_monotonic_violations", bad, 0);
      end
`endif

      // Enable dropped for five cycles mid-run.
      inc = 32'h00A3_1234;
      for (int i = 0; i < 20; i++) step(1'b0, 1'b1, inc);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, inc);
         if (i == 0) begin
            prev_s = sin_out; prev_c = cos_out; prev_q = squ_out; prev_w = saw_out;
         end else begin
            check_val("hold_sin", sin_out, prev_s);
            check_val("hold_cos", cos_out, prev_c);
            check_val("hold_squ", squ_out, prev_q);
            check_val("hold_saw", saw_out, prev_w);
         end
      end
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, inc);

      // One-cycle reset pulse while running.
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h1234_5678);
      step(1'b1, 1'b1, 32'h1234_5678);
      check_val("pulse_sin", sin_out, 0);
      check_val("pulse_cos", cos_out, 0);
      check_val("pulse_squ", squ_out, 0);
      check_val("pulse_saw", saw_out, 0);
      step(1'b0, 1'b1, 32'h1234_5678);
      check_val("restart_sin", sin_out, 0);
      check_val("restart_cos", cos_out, 2047);
      check_val("restart_squ", squ_out, 2047);
      check_val("restart_saw", saw_out, -2048);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h1234_5678);

      // Random tuning words, enables and occasional resets.
      inc = $urandom;
      for (int i = 0; i < 400; i++) begin
         bit r, e;
         r = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 15))
            0:       inc = 32'd0;
            1:       inc = 32'h8000_0000 | $urandom;
            2, 3:    inc = $urandom;
            default: ;
         endcase
         step(r, e, inc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
